// File: rtl/gate_truth_table_checker.sv
// Stimulus/response checker for a 2-input gate: sweeps all four input vectors,
// samples the gate output after a settle delay and compares it against EXPECTED.
// Optional macro GATE_CHK_ERR_CNT_EN adds a saturating mismatch counter (err_cnt).
module gate_truth_table_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] captured,
    output logic [3:0] fail_vec
`ifdef GATE_CHK_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int unsigned SETTLE = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned CNT_W  = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in1_q, in1_d;
    logic             in2_q, in2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       captured_q, captured_d;
    logic [3:0]       fail_vec_q, fail_vec_d;
    logic             mismatch;

    assign mismatch = dut_out ^ EXPECTED[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            in1_q      <= 1'b0;
            in2_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= 4'd0;
            fail_vec_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            captured_q <= captured_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        captured_d = captured_q;
        fail_vec_d = fail_vec_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_DRIVE;
                    idx_d      = 2'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    captured_d = 4'd0;
                    fail_vec_d = 4'd0;
                end
            end
            ST_DRIVE: begin
                in1_d   = idx_q[1];
                in2_d   = idx_q[0];
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                captured_d[idx_q] = dut_out;
                fail_vec_d[idx_q] = mismatch;
                if (idx_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                // fail_vec already holds the last vector's result here
                in1_d   = 1'b0;
                in2_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (fail_vec_q == 4'd0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef GATE_CHK_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Survives start so it accumulates across sweeps; only rst clears it
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == ST_SAMPLE) && mismatch && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign in1      = in1_q;
    assign in2      = in2_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign captured = captured_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Scoreboard bench for gate_truth_table_checker: three instances (SETTLE 2, 0, 3)
// driving behavioural gate models; expected sweep results are queued at start.
module tb_gate_truth_table_checker;

    typedef struct {
        logic [3:0] cap;
        logic [3:0] fv;
        logic       pass;
        logic [7:0] err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_bc = 1'b0;
    int   mode_a = 0;

    logic in1_a, in2_a, busy_a, done_a, pass_a, dout_a;
    logic [3:0] cap_a, fv_a;
    logic [7:0] err_a;
    logic in1_b, in2_b, busy_b, done_b, pass_b;
    logic [3:0] cap_b, fv_b;
    logic [7:0] err_b;
    logic in1_c, in2_c, busy_c, done_c, pass_c;
    logic [3:0] cap_c, fv_c;
    logic [7:0] err_c;

    logic pb1 = 1'b1, pb2 = 1'b1, pc1 = 1'b1, pc2 = 1'b1;

    int checks = 0;
    int errors = 0;
    int exp_err_a = 0, exp_err_b = 0, exp_err_c = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    logic done_a_prev = 1'b0, done_b_prev = 1'b0, done_c_prev = 1'b0;

    always #5 clk = ~clk;

    // Gate models: A selectable (NAND / stuck-1 / AND), B and C NAND with 2-clock latency
    always_comb begin
        case (mode_a)
            0:       dout_a = ~(in1_a & in2_a);
            1:       dout_a = 1'b1;
            default: dout_a = in1_a & in2_a;
        endcase
    end

    always @(posedge clk) begin
        pb1 <= ~(in1_b & in2_b);
        pb2 <= pb1;
        pc1 <= ~(in1_c & in2_c);
        pc2 <= pc1;
    end

    gate_truth_table_checker #(.SETTLE_CYCLES(2), .EXPECTED(4'b0111)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_out(dout_a),
        .in1(in1_a), .in2(in2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .captured(cap_a), .fail_vec(fv_a)
`ifdef GATE_CHK_ERR_CNT_EN
        , .err_cnt(err_a)
`endif
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(0), .EXPECTED(4'b0111)) u_b (
        .clk(clk), .rst(rst), .start(start_bc), .dut_out(pb2),
        .in1(in1_b), .in2(in2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .captured(cap_b), .fail_vec(fv_b)
`ifdef GATE_CHK_ERR_CNT_EN
        , .err_cnt(err_b)
`endif
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(3), .EXPECTED(4'b0111)) u_c (
        .clk(clk), .rst(rst), .start(start_bc), .dut_out(pc2),
        .in1(in1_c), .in2(in2_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .captured(cap_c), .fail_vec(fv_c)
`ifdef GATE_CHK_ERR_CNT_EN
        , .err_cnt(err_c)
`endif
    );

`ifndef GATE_CHK_ERR_CNT_EN
    assign err_a = 8'd0;
    assign err_b = 8'd0;
    assign err_c = 8'd0;
`endif

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic compare(input string who, input exp_t e, input logic [3:0] cap,
                           input logic [3:0] fv, input logic pass, input logic busy,
                           input logic [7:0] err);
        chk({who, "_captured"}, {4'd0, cap}, {4'd0, e.cap});
        chk({who, "_fail_vec"}, {4'd0, fv}, {4'd0, e.fv});
        chk({who, "_pass"}, {7'd0, pass}, {7'd0, e.pass});
        chk({who, "_busy_at_done"}, {7'd0, busy}, 8'd0);
`ifdef GATE_CHK_ERR_CNT_EN
        chk({who, "_err_cnt"}, err, e.err);
`else
        if (err !== 8'd0) chk({who, "_err_tie"}, err, 8'd0);
`endif
    endtask

    always @(negedge clk) begin
        if (done_a && !done_a_prev) begin
            if (q_a.size() == 0) chk("A_unexpected_done", 8'd1, 8'd0);
            else compare("A", q_a.pop_front(), cap_a, fv_a, pass_a, busy_a, err_a);
        end
        if (done_b && !done_b_prev) begin
            if (q_b.size() == 0) chk("B_unexpected_done", 8'd1, 8'd0);
            else compare("B", q_b.pop_front(), cap_b, fv_b, pass_b, busy_b, err_b);
        end
        if (done_c && !done_c_prev) begin
            if (q_c.size() == 0) chk("C_unexpected_done", 8'd1, 8'd0);
            else compare("C", q_c.pop_front(), cap_c, fv_c, pass_c, busy_c, err_c);
        end
        done_a_prev = done_a;
        done_b_prev = done_b;
        done_c_prev = done_c;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic push_a(input logic [3:0] cap, input logic [3:0] fv, input logic p, input int nerr);
        exp_err_a = sat(exp_err_a + nerr);
        q_a.push_back('{cap: cap, fv: fv, pass: p, err: 8'(exp_err_a)});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_err_a = 0;
        exp_err_b = 0;
        exp_err_c = 0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            tick();
            n++;
        end
        if (!done_a) chk("A_done_timeout", 8'd0, 8'd1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_in"}, {6'd0, in1_a, in2_a}, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy_a}, 8'd0);
        chk({tag, "_done"}, {7'd0, done_a}, 8'd0);
        chk({tag, "_pass"}, {7'd0, pass_a}, 8'd0);
        chk({tag, "_captured"}, {4'd0, cap_a}, 8'd0);
        chk({tag, "_fail_vec"}, {4'd0, fv_a}, 8'd0);
`ifdef GATE_CHK_ERR_CNT_EN
        chk({tag, "_err_cnt"}, err_a, 8'd0);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();
        check_cleared("reset");

        // B (settle 0 -> 1) samples one vector stale; C (settle 3) sees the true NAND
        exp_err_b = sat(exp_err_b + 1);
        q_b.push_back('{cap: 4'b1111, fv: 4'b1000, pass: 1'b0, err: 8'(exp_err_b)});
        q_c.push_back('{cap: 4'b0111, fv: 4'b0000, pass: 1'b1, err: 8'(exp_err_c)});
        start_bc = 1'b1;
        tick();
        start_bc = 1'b0;
        n = 0;
        while (!(done_b && done_c) && n < 60) begin
            tick();
            n++;
        end
        if (!(done_b && done_c)) chk("BC_done_timeout", 8'd0, 8'd1);
        tick();

        // Ideal NAND with vector timing checks (E0 = accept edge)
        mode_a = 0;
        push_a(4'b0111, 4'b0000, 1'b1, 0);
        pulse_start_a();
        chk("E0_busy", {7'd0, busy_a}, 8'd1);
        tick();
        chk("E1_vec", {6'd0, in1_a, in2_a}, 8'd0);
        repeat (4) tick();
        chk("E5_vec", {6'd0, in1_a, in2_a}, 8'd1);
        repeat (4) tick();
        chk("E9_vec", {6'd0, in1_a, in2_a}, 8'd2);
        repeat (4) tick();
        chk("E13_vec", {6'd0, in1_a, in2_a}, 8'd3);
        repeat (3) tick();
        chk("E16_done_low", {7'd0, done_a}, 8'd0);
        tick();
        chk("E17_done", {7'd0, done_a}, 8'd1);
        chk("E17_vec", {6'd0, in1_a, in2_a}, 8'd0);
        tick();

        // Stuck-at-1 output
        mode_a = 1;
        push_a(4'b1111, 4'b1000, 1'b0, 1);
        pulse_start_a();
        wait_done_a(40);
        tick();

        // AND gate in place of NAND, twice to show error accumulation
        do_reset();
        mode_a = 2;
        push_a(4'b1000, 4'b1111, 1'b0, 4);
        pulse_start_a();
        wait_done_a(40);
        tick();
        push_a(4'b1000, 4'b1111, 1'b0, 4);
        pulse_start_a();
        wait_done_a(40);
        tick();

        // start held for 40 edges: sweeps accepted at E0, E18, E36
        mode_a = 0;
        push_a(4'b0111, 4'b0000, 1'b1, 0);
        push_a(4'b0111, 4'b0000, 1'b1, 0);
        push_a(4'b0111, 4'b0000, 1'b1, 0);
        start_a = 1'b1;
        tick();
        for (int i = 1; i < 40; i++) begin
            tick();
            if (i == 17) chk("held_E17_done", {7'd0, done_a}, 8'd1);
            if (i == 18) begin
                chk("held_E18_done_clear", {7'd0, done_a}, 8'd0);
                chk("held_E18_busy", {7'd0, busy_a}, 8'd1);
            end
        end
        start_a = 1'b0;
        wait_done_a(40);
        tick();

        // Extra start pulse mid-sweep must not queue a second sweep
        push_a(4'b0111, 4'b0000, 1'b1, 0);
        pulse_start_a();
        repeat (5) tick();
        pulse_start_a();
        wait_done_a(40);
        repeat (5) tick();
        chk("midpulse_busy", {7'd0, busy_a}, 8'd0);
        chk("midpulse_done_held", {7'd0, done_a}, 8'd1);

        // Reset at E6 mid-sweep, then a full clean sweep
        pulse_start_a();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        exp_err_a = 0;
        check_cleared("midreset");
        rst = 1'b0;
        tick();
        push_a(4'b0111, 4'b0000, 1'b1, 0);
        pulse_start_a();
        wait_done_a(40);
        tick();
        tick();

        chk("A_queue_drained", 8'(q_a.size()), 8'd0);
        chk("B_queue_drained", 8'(q_b.size()), 8'd0);
        chk("C_queue_drained", 8'(q_c.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
